// File: rtl/pipeline_stage_memory.sv
// pipeline_stage_memory: memory stage (stage 4) of the pipeline.
//   Takes the execution-stage result register, issues at most one data-memory
//   load/store per instruction over a ready handshake, and registers the
//   result for write-back. Stalls upstream while the data memory is busy and
//   publishes its output register contents for forwarding into execution.
//
// Ports:
//   clock, reset                    sole clock, async active-high reset
//   pipelineResultExecuation        execution-stage result register
//   dmemReady / dmemReadData        memory completion and load data
//   dmemRequest / dmemWrite         access request, 1 = store
//   dmemAddress / dmemWriteData     access address and store data
//   pipelineResultMemory            registered stage output
//   stallOnMemory                   upstream must hold its register
//   resultOfInstructionAfterMemory  forwarding view of the output register
//   memoryFault                     sticky access-timeout flag
//
// Optional feature: define PIPELINE_MEMORY_TIMEOUT_EN to abort accesses that
// wait TIMEOUT_CYCLES cycles. Without it, a wait lasts until dmemReady and
// memoryFault is tied low.
//
// state | meaning
// IDLE  | no access outstanding from an earlier cycle
// WAIT  | access issued, data memory has not completed it yet

package pipeline_stage_memory_pkg;

  typedef enum logic [1:0] {
    REG_WRITE_FROM_ALU    = 2'd0,
    REG_WRITE_FROM_MEMORY = 2'd1,
    REG_WRITE_FROM_PC     = 2'd2
  } reg_write_from_t;

  typedef struct packed {
    logic            memReadEnabled;
    logic            memWriteEnabled;
    logic            regWriteEnabled;
    reg_write_from_t regDataWriteFrom;
  } control_signals_t;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
  } reg_read_id_t;

  typedef struct packed {
    logic [31:0] data1;
    logic [31:0] data2;
  } reg_data_t;

  typedef struct packed {
    logic [31:0]      programCounter;
    logic [31:0]      instruction;
    control_signals_t signals;
    reg_read_id_t     regReadId;
    reg_data_t        regData;
    logic [4:0]       regWriteId;
    logic [31:0]      aluResult;
    logic             regDataWriteReady;
    logic [31:0]      regDataWrite;
    logic             forwardStall;
  } pipeline_result_execuation_t;

  typedef struct packed {
    logic [31:0]      programCounter;
    logic [31:0]      instruction;
    control_signals_t signals;
    reg_read_id_t     regReadId;
    reg_data_t        regData;
    logic [4:0]       regWriteId;
    logic [31:0]      aluResult;
    logic             regDataWriteReady;
    logic [31:0]      regDataWrite;
    logic             forwardStall;
  } pipeline_result_memory_t;

  typedef struct packed {
    logic [4:0]  registerId;
    logic        dataReady;
    logic [31:0] data;
  } stage_register_data_t;

endpackage

module pipeline_stage_memory
  import pipeline_stage_memory_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                        clock,
  input  logic                        reset,
  input  pipeline_result_execuation_t pipelineResultExecuation,
  input  logic                        dmemReady,
  input  logic [31:0]                 dmemReadData,
  output logic                        dmemRequest,
  output logic                        dmemWrite,
  output logic [31:0]                 dmemAddress,
  output logic [31:0]                 dmemWriteData,
  output pipeline_result_memory_t     pipelineResultMemory,
  output logic                        stallOnMemory,
  output stage_register_data_t        resultOfInstructionAfterMemory,
  output logic                        memoryFault
);

  // The wait counter is 8 bits wide, so the limit must fit in 1..255.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_timeout_range
    $error("pipeline_stage_memory: TIMEOUT_CYCLES must be in 1..255");
  end

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  pipeline_result_memory_t out_q, out_d;

  logic is_bubble;
  logic mem_op;
  logic aborting;
  logic stall;

  assign is_bubble = pipelineResultExecuation.forwardStall;
  assign mem_op    = !is_bubble &&
                     (pipelineResultExecuation.signals.memReadEnabled ||
                      pipelineResultExecuation.signals.memWriteEnabled);

`ifdef PIPELINE_MEMORY_TIMEOUT_EN
  localparam logic [7:0] TimeoutCount = 8'(TIMEOUT_CYCLES);

  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       memory_fault_q, memory_fault_d;

  // The abort cycle still sits in WAIT; the request is withdrawn and the
  // instruction retires with zero data in that same cycle.
  assign aborting = (state_q == ST_WAIT) && (wait_cnt_q == TimeoutCount);

  always_comb begin
    wait_cnt_d     = 8'd0;
    memory_fault_d = memory_fault_q || aborting;
    if (state_q == ST_WAIT && state_d == ST_WAIT) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_cnt_q     <= 8'd0;
      memory_fault_q <= 1'b0;
    end else begin
      wait_cnt_q     <= wait_cnt_d;
      memory_fault_q <= memory_fault_d;
    end
  end

  assign memoryFault = memory_fault_q;
`else
  assign aborting    = 1'b0;
  assign memoryFault = 1'b0;
`endif

  assign stall = mem_op && !dmemReady && !aborting;

  // Request is gated by reset directly so it drops the moment reset rises.
  assign dmemRequest   = mem_op && !aborting && !reset;
  assign dmemWrite     = pipelineResultExecuation.signals.memWriteEnabled;
  assign dmemAddress   = pipelineResultExecuation.aluResult;
  assign dmemWriteData = pipelineResultExecuation.regData.data2;
  assign stallOnMemory = stall;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (mem_op && !dmemReady) state_d = ST_WAIT;
      ST_WAIT: if (dmemReady || aborting || !mem_op) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    out_d              = out_q;
    out_d.forwardStall = stall || is_bubble;
    if (!stall && !is_bubble) begin
      out_d.programCounter = pipelineResultExecuation.programCounter;
      out_d.instruction    = pipelineResultExecuation.instruction;
      out_d.signals        = pipelineResultExecuation.signals;
      out_d.regReadId      = pipelineResultExecuation.regReadId;
      out_d.regData        = pipelineResultExecuation.regData;
      out_d.regWriteId     = pipelineResultExecuation.regWriteId;
      out_d.aluResult      = pipelineResultExecuation.aluResult;
      if (!pipelineResultExecuation.signals.regWriteEnabled) begin
        out_d.regDataWriteReady = 1'b1;
        out_d.regDataWrite      = 32'd0;
      end else if (pipelineResultExecuation.regDataWriteReady) begin
        out_d.regDataWriteReady = 1'b1;
        out_d.regDataWrite      = pipelineResultExecuation.regDataWrite;
      end else if (pipelineResultExecuation.signals.regDataWriteFrom == REG_WRITE_FROM_MEMORY) begin
        out_d.regDataWriteReady = 1'b1;
        out_d.regDataWrite      = aborting ? 32'd0 : dmemReadData;
      end else begin
        // Value produced by a later stage; pass it through still pending.
        out_d.regDataWriteReady = 1'b0;
        out_d.regDataWrite      = pipelineResultExecuation.regDataWrite;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q                 <= ST_IDLE;
      out_q                   <= '0;
      out_q.regDataWriteReady <= 1'b1;
      out_q.forwardStall      <= 1'b1;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
    end
  end

  assign pipelineResultMemory = out_q;

  assign resultOfInstructionAfterMemory.registerId = out_q.regWriteId;
  assign resultOfInstructionAfterMemory.dataReady  = out_q.regDataWriteReady;
  assign resultOfInstructionAfterMemory.data       = out_q.regDataWrite;

endmodule

// File: tb/tb_pipeline_stage_memory.sv
module tb_pipeline_stage_memory;
  import pipeline_stage_memory_pkg::*;

  logic                        clock;
  logic                        reset;
  pipeline_result_execuation_t pr_in;
  logic                        dmemReady;
  logic [31:0]                 dmemReadData;
  logic                        dmemRequest;
  logic                        dmemWrite;
  logic [31:0]                 dmemAddress;
  logic [31:0]                 dmemWriteData;
  pipeline_result_memory_t     pr_out;
  logic                        stallOnMemory;
  stage_register_data_t        fwd;
  logic                        memoryFault;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        ready;
    logic [31:0] data;
  } exp_t;

  exp_t sb_q[$];
  exp_t sb_e;
  int   checks = 0;
  int   errors = 0;

  localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_BUBBLE = 3;

  pipeline_stage_memory #(.TIMEOUT_CYCLES(4)) dut (
    .clock                          (clock),
    .reset                          (reset),
    .pipelineResultExecuation       (pr_in),
    .dmemReady                      (dmemReady),
    .dmemReadData                   (dmemReadData),
    .dmemRequest                    (dmemRequest),
    .dmemWrite                      (dmemWrite),
    .dmemAddress                    (dmemAddress),
    .dmemWriteData                  (dmemWriteData),
    .pipelineResultMemory           (pr_out),
    .stallOnMemory                  (stallOnMemory),
    .resultOfInstructionAfterMemory (fwd),
    .memoryFault                    (memoryFault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Scoreboard: every cycle the stage retires an instruction, compare it
  // against the oldest expectation.
  always @(posedge clock) begin
    #1;
    if (!reset && pr_out.forwardStall === 1'b0) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: output pc=%h rd=%0d with no expectation", pr_out.programCounter, pr_out.regWriteId);
      end else begin
        sb_e = sb_q.pop_front();
        if (pr_out.programCounter !== sb_e.pc || pr_out.regWriteId !== sb_e.rd ||
            pr_out.regDataWriteReady !== sb_e.ready || pr_out.regDataWrite !== sb_e.data) begin
          errors++;
          $display("FAIL sb_result: got pc=%h rd=%0d rdy=%b data=%h expected pc=%h rd=%0d rdy=%b data=%h",
                   pr_out.programCounter, pr_out.regWriteId, pr_out.regDataWriteReady, pr_out.regDataWrite,
                   sb_e.pc, sb_e.rd, sb_e.ready, sb_e.data);
        end
      end
    end
  end

  function automatic pipeline_result_execuation_t mk(input int kind, input logic [31:0] pc,
                                                     input logic [31:0] alu, input logic [31:0] d2,
                                                     input logic [4:0] rd);
    pipeline_result_execuation_t x;
    x = '0;
    x.programCounter        = pc;
    x.instruction           = pc ^ 32'h1357_9bdf;
    x.regReadId.rs1         = 5'd1;
    x.regReadId.rs2         = 5'd2;
    x.regData.data1         = 32'h0bad_f00d;
    x.regData.data2         = d2;
    x.regWriteId            = rd;
    x.aluResult             = alu;
    x.signals.regDataWriteFrom = REG_WRITE_FROM_ALU;
    case (kind)
      K_ALU: begin
        x.signals.regWriteEnabled = 1'b1;
        x.regDataWriteReady       = 1'b1;
        x.regDataWrite            = alu;
      end
      K_LOAD: begin
        x.signals.memReadEnabled   = 1'b1;
        x.signals.regWriteEnabled  = 1'b1;
        x.signals.regDataWriteFrom = REG_WRITE_FROM_MEMORY;
      end
      K_STORE: begin
        x.signals.memWriteEnabled = 1'b1;
      end
      default: begin
        // Bubble carrying stale memory-op bits that must be ignored.
        x.signals.memReadEnabled = 1'b1;
        x.forwardStall           = 1'b1;
      end
    endcase
    return x;
  endfunction

  task automatic tick;
    @(posedge clock);
    #2;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    pr_in = mk(K_LOAD, 32'h100, 32'h40, 32'h0, 5'd3);
    dmemReady = 1'b0;
    #3;
    checks++;
    if (pr_out.forwardStall !== 1'b1 || pr_out.regDataWriteReady !== 1'b1 || dmemRequest !== 1'b0 ||
        fwd.registerId !== 5'd0 || pr_out.regDataWrite !== 32'd0 || memoryFault !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: fs=%b rdy=%b req=%b regid=%0d data=%h fault=%b expected 1 1 0 0 0 0",
               pr_out.forwardStall, pr_out.regDataWriteReady, dmemRequest, fwd.registerId, pr_out.regDataWrite, memoryFault);
    end
    pr_in = mk(K_BUBBLE, 32'h0, 32'h0, 32'h0, 5'd0);
    tick;
    tick;
    reset = 1'b0;
    tick;
    checks++;
    if (pr_out.forwardStall !== 1'b1 || pr_out.programCounter !== 32'd0 || dmemRequest !== 1'b0) begin
      errors++;
      $display("FAIL bubble_after_reset: fs=%b pc=%h req=%b expected 1 0 0", pr_out.forwardStall, pr_out.programCounter, dmemRequest);
    end
  endtask

  task automatic test_alu;
    pr_in = mk(K_ALU, 32'h200, 32'h1234, 32'h0, 5'd5);
    dmemReady = 1'b0;
    #1;
    checks++;
    if (stallOnMemory !== 1'b0 || dmemRequest !== 1'b0) begin
      errors++;
      $display("FAIL alu_no_stall: stall=%b req=%b expected 0 0", stallOnMemory, dmemRequest);
    end
    sb_q.push_back('{pc: 32'h200, rd: 5'd5, ready: 1'b1, data: 32'h1234});
    tick;
    checks++;
    if (fwd.data !== 32'h1234 || fwd.registerId !== 5'd5 || fwd.dataReady !== 1'b1 || pr_out.forwardStall !== 1'b0) begin
      errors++;
      $display("FAIL alu_result: data=%h id=%0d rdy=%b fs=%b expected 00001234 5 1 0", fwd.data, fwd.registerId, fwd.dataReady, pr_out.forwardStall);
    end
  endtask

  task automatic test_bubble;
    pr_in = mk(K_BUBBLE, 32'h300, 32'h999, 32'h0, 5'd9);
    dmemReady = 1'b1;
    dmemReadData = 32'h7777_7777;
    #1;
    checks++;
    if (dmemRequest !== 1'b0 || stallOnMemory !== 1'b0) begin
      errors++;
      $display("FAIL bubble_no_request: req=%b stall=%b expected 0 0", dmemRequest, stallOnMemory);
    end
    tick;
    checks++;
    if (pr_out.forwardStall !== 1'b1 || fwd.registerId !== 5'd5 || fwd.data !== 32'h1234 || pr_out.programCounter !== 32'h200) begin
      errors++;
      $display("FAIL bubble_hold: fs=%b id=%0d data=%h pc=%h expected 1 5 00001234 00000200",
               pr_out.forwardStall, fwd.registerId, fwd.data, pr_out.programCounter);
    end
  endtask

  task automatic test_load_wait;
    pr_in = mk(K_LOAD, 32'h400, 32'h40, 32'h0, 5'd7);
    dmemReady = 1'b0;
    dmemReadData = 32'h0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (stallOnMemory !== 1'b1 || dmemRequest !== 1'b1 || dmemAddress !== 32'h40 || dmemWrite !== 1'b0) begin
        errors++;
        $display("FAIL load_wait_%0d: stall=%b req=%b addr=%h wr=%b expected 1 1 00000040 0",
                 i, stallOnMemory, dmemRequest, dmemAddress, dmemWrite);
      end
      tick;
      checks++;
      if (pr_out.forwardStall !== 1'b1) begin
        errors++;
        $display("FAIL load_wait_fs_%0d: fs=%b expected 1", i, pr_out.forwardStall);
      end
    end
    dmemReady = 1'b1;
    dmemReadData = 32'hDEAD_BEEF;
    sb_q.push_back('{pc: 32'h400, rd: 5'd7, ready: 1'b1, data: 32'hDEAD_BEEF});
    #1;
    checks++;
    if (stallOnMemory !== 1'b0 || dmemRequest !== 1'b1 || dmemAddress !== 32'h40) begin
      errors++;
      $display("FAIL load_ready_cycle: stall=%b req=%b addr=%h expected 0 1 00000040", stallOnMemory, dmemRequest, dmemAddress);
    end
    tick;
    checks++;
    if (pr_out.forwardStall !== 1'b0 || fwd.data !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL load_result: fs=%b data=%h expected 0 deadbeef", pr_out.forwardStall, fwd.data);
    end
  endtask

  task automatic test_store;
    pr_in = mk(K_STORE, 32'h500, 32'h80, 32'h55, 5'd11);
    dmemReady = 1'b1;
    dmemReadData = 32'hFFFF_FFFF;
    sb_q.push_back('{pc: 32'h500, rd: 5'd11, ready: 1'b1, data: 32'h0});
    #1;
    checks++;
    if (dmemWrite !== 1'b1 || dmemRequest !== 1'b1 || stallOnMemory !== 1'b0 ||
        dmemAddress !== 32'h80 || dmemWriteData !== 32'h55) begin
      errors++;
      $display("FAIL store_request: wr=%b req=%b stall=%b addr=%h wdata=%h expected 1 1 0 00000080 00000055",
               dmemWrite, dmemRequest, stallOnMemory, dmemAddress, dmemWriteData);
    end
    tick;
  endtask

  task automatic test_back_to_back;
    int          kind;
    int          waits;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [4:0]  rd;
    for (int n = 0; n < 12; n++) begin
      kind  = $urandom_range(0, 2);
      waits = (kind == K_ALU) ? 0 : $urandom_range(0, 2);
      alu   = $urandom;
      rdata = $urandom;
      rd    = 5'($urandom_range(1, 31));
      pr_in = mk(kind, 32'h1000 + 32'(n * 4), alu, ~alu, rd);
      dmemReady = 1'b0;
      for (int w = 0; w < waits; w++) begin
        #1;
        checks++;
        if (stallOnMemory !== 1'b1) begin
          errors++;
          $display("FAIL b2b_stall n=%0d w=%0d: stall=%b expected 1", n, w, stallOnMemory);
        end
        tick;
      end
      dmemReady = 1'b1;
      dmemReadData = rdata;
      sb_q.push_back('{pc: 32'h1000 + 32'(n * 4), rd: rd, ready: 1'b1,
                       data: (kind == K_ALU) ? alu : (kind == K_LOAD) ? rdata : 32'h0});
      #1;
      checks++;
      if (stallOnMemory !== 1'b0 || dmemRequest !== (kind != K_ALU)) begin
        errors++;
        $display("FAIL b2b_issue n=%0d: stall=%b req=%b expected 0 %b", n, stallOnMemory, dmemRequest, kind != K_ALU);
      end
      tick;
    end
    pr_in = mk(K_BUBBLE, 32'h0, 32'h0, 32'h0, 5'd0);
    dmemReady = 1'b0;
    tick;
  endtask

  task automatic test_reset_mid_wait;
    pr_in = mk(K_LOAD, 32'h600, 32'h64, 32'h0, 5'd13);
    dmemReady = 1'b0;
    tick;
    tick;
    #1;
    checks++;
    if (dmemRequest !== 1'b1 || stallOnMemory !== 1'b1) begin
      errors++;
      $display("FAIL midwait_pending: req=%b stall=%b expected 1 1", dmemRequest, stallOnMemory);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (dmemRequest !== 1'b0 || pr_out.forwardStall !== 1'b1 || pr_out.regDataWriteReady !== 1'b1 ||
        pr_out.regDataWrite !== 32'd0 || pr_out.regWriteId !== 5'd0 || pr_out.programCounter !== 32'd0) begin
      errors++;
      $display("FAIL midwait_reset: req=%b fs=%b rdy=%b data=%h id=%0d pc=%h expected 0 1 1 0 0 0",
               dmemRequest, pr_out.forwardStall, pr_out.regDataWriteReady, pr_out.regDataWrite,
               pr_out.regWriteId, pr_out.programCounter);
    end
    pr_in = mk(K_BUBBLE, 32'h0, 32'h0, 32'h0, 5'd0);
    tick;
    reset = 1'b0;
    tick;
    pr_in = mk(K_ALU, 32'h700, 32'h4242, 32'h0, 5'd14);
    sb_q.push_back('{pc: 32'h700, rd: 5'd14, ready: 1'b1, data: 32'h4242});
    #1;
    checks++;
    if (stallOnMemory !== 1'b0 || dmemRequest !== 1'b0) begin
      errors++;
      $display("FAIL midwait_resume: stall=%b req=%b expected 0 0", stallOnMemory, dmemRequest);
    end
    tick;
    pr_in = mk(K_BUBBLE, 32'h0, 32'h0, 32'h0, 5'd0);
    tick;
  endtask

`ifdef PIPELINE_MEMORY_TIMEOUT_EN
  task automatic test_timeout;
    int n;
    pr_in = mk(K_LOAD, 32'h800, 32'h88, 32'h0, 5'd15);
    dmemReady = 1'b0;
    dmemReadData = 32'hCAFE_CAFE;
    n = 0;
    #1;
    while (stallOnMemory === 1'b1 && n < 20) begin
      n++;
      tick;
      #1;
    end
    checks++;
    if (n != 5 || dmemRequest !== 1'b0) begin
      errors++;
      $display("FAIL timeout_abort: stall cycles=%0d req=%b expected 5 0", n, dmemRequest);
    end
    sb_q.push_back('{pc: 32'h800, rd: 5'd15, ready: 1'b1, data: 32'h0});
    tick;
    checks++;
    if (memoryFault !== 1'b1) begin
      errors++;
      $display("FAIL timeout_fault: fault=%b expected 1", memoryFault);
    end
    pr_in = mk(K_BUBBLE, 32'h0, 32'h0, 32'h0, 5'd0);
    tick;
    tick;
    checks++;
    if (memoryFault !== 1'b1) begin
      errors++;
      $display("FAIL timeout_sticky: fault=%b expected 1", memoryFault);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (memoryFault !== 1'b0) begin
      errors++;
      $display("FAIL timeout_clear: fault=%b expected 0", memoryFault);
    end
    tick;
    reset = 1'b0;
    tick;
  endtask
`endif

  initial begin
    reset = 1'b1;
    pr_in = '0;
    dmemReady = 1'b0;
    dmemReadData = 32'h0;
    test_reset;
    test_alu;
    test_bubble;
    test_load_wait;
    test_store;
    test_back_to_back;
    test_reset_mid_wait;
`ifdef PIPELINE_MEMORY_TIMEOUT_EN
    test_timeout;
`endif
    tick;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d expectations left, expected 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pipeline_stage_memory.md
# pipeline_stage_memory

Stage 4 of the pipeline: takes the execution-stage result register, performs at most one data-memory load or store per instruction over a ready-based handshake, and registers the result for write-back. It stalls the upstream stages while the data memory is busy. It publishes its own register-write data for hazard forwarding into the execution stage, as `resultOfInstructionAfterMemory`.

## Interface
- `TIMEOUT_CYCLES`, default 255: wait-cycle limit before a memory access is aborted. Used only with `PIPELINE_MEMORY_TIMEOUT_EN`.
- `clock`  in  1  sole clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-high.
- `pipelineResultExecuation`  in  `pipeline_result_execuation_t`  execution-stage result register.
- `dmemReady`  in  1  data memory completes the current request in this cycle.
- `dmemReadData`  in  32  load data; valid when `dmemReady`=1.
- `dmemRequest`  out  1  access request.
- `dmemWrite`  out  1  1 = store, 0 = load.
- `dmemAddress`  out  32  access address.
- `dmemWriteData`  out  32  store data.
- `pipelineResultMemory`  out  `pipeline_result_memory_t`  execution fields plus final `regDataWriteReady`/`regDataWrite` and `forwardStall`.
- `stallOnMemory`  out  1  upstream must hold.
- `resultOfInstructionAfterMemory`  out  `stage_register_data_t`  forwarding info from this stage's output register.
- `memoryFault`  out  1  sticky access-timeout flag.

## Operation
- The input is a bubble when `in.forwardStall`=1.
- A memory op is a non-bubble input with `signals.memReadEnabled` or `signals.memWriteEnabled` set.
- Request signals are combinational from input and state:
  - `dmemRequest` = memOp and not aborting.
  - `dmemWrite` = `memWriteEnabled`.
  - `dmemAddress` = `aluResult`.
  - `dmemWriteData` = `regData.data2`.
  - These stay stable while the request is pending.
- `stallOnMemory` = memOp && !`dmemReady` (comb). Upstream holds its register while this is high.
- FSM, 2 states:
  - IDLE → WAIT on memOp && !`dmemReady`.
  - WAIT → IDLE on `dmemReady` (or on timeout).
  - WAIT keeps `dmemRequest` high.
- Output register updates only when not stalled and the input is not a bubble:
  - Copies `programCounter`, `instruction`, `signals`, `regReadId`, `regData`, `regWriteId`, `aluResult`.
  - `regDataWrite`: input data if already ready. Otherwise, if `regDataWriteFrom`==`REG_WRITE_FROM_MEMORY`, `dmemReadData` with ready=1. Write-disabled instructions give ready=1, data=0.
- `out.forwardStall` <= `stallOnMemory` || `in.forwardStall`, every cycle. All other output fields hold during stalls and bubbles.
- `resultOfInstructionAfterMemory` = {`out.regWriteId`, `out.regDataWriteReady`, `out.regDataWrite`}, combinational from the output register.

## Timing
- Non-memory instruction: 1-cycle latency.
- Load or store with `dmemReady` in the request cycle: 1 cycle, no stall.
- Load or store with N wait cycles: N stall cycles, then result registered on the ready edge.
- Reset values:
  - State IDLE.
  - Every `pipelineResultMemory` field 0, except `regDataWriteReady`=1 and `forwardStall`=1.
  - `memoryFault`=0.
  - `dmemRequest` falls immediately on `reset` assertion.
- Reset mid-WAIT: access abandoned; no output update; resume in IDLE.
- `dmemReady` while no request: ignored.

## Configuration
- `PIPELINE_MEMORY_TIMEOUT_EN` defined:
  - An 8-bit wait counter counts WAIT cycles.
  - On reaching `TIMEOUT_CYCLES`: `dmemRequest` drops, `stallOnMemory` drops, and the instruction is registered with `regDataWrite`=0, ready=1.
  - `memoryFault` is set until reset. The counter clears on every IDLE entry.
- Not defined: WAIT lasts until `dmemReady`; `memoryFault` tied 0; no counter logic.

## Test plan
- After reset: `pipelineResultMemory.forwardStall`=1, `regDataWriteReady`=1, `dmemRequest`=0, `resultOfInstructionAfterMemory.registerId`=0.
- ALU instruction, `aluResult`=0x1234, regWriteId=5 → next cycle output regDataWrite=0x1234, ready=1, no stall, no request.
- Load at address 0x40, `dmemReady` held 0 for 3 cycles then 1 with data 0xDEADBEEF:
  - `stallOnMemory` high for 3 cycles.
  - Address stable at 0x40.
  - Output regDataWrite=0xDEADBEEF on the ready edge; `out.forwardStall` 1 for 3 cycles then 0.
- Store, `aluResult`=0x80, `regData.data2`=0x55, `dmemReady`=1 same cycle → `dmemWrite`=1, no stall, output regDataWrite=0 ready=1.
- Reset asserted mid-WAIT → `dmemRequest` drops the same cycle; FSM in IDLE; output equals reset values.
- With `PIPELINE_MEMORY_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4, `dmemReady` stuck 0 → abort after 4 WAIT cycles; `memoryFault`=1 until reset; regDataWrite=0.
